// File: rtl/hbm_wr_arbiter_pkg.sv
// Shared widths, AXI encodings and FSM state type for the HBM write-port arbiter.
package hbm_arb_pkg;
   localparam int AXI_AW = 29;
   localparam int AXI_DW = 128;
   localparam int LEN_W  = 8;
   localparam int ID_W   = 4;
   localparam int GID_W  = 3;

   localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      AWR  = 2'd1,
      WR   = 2'd2,
      BR   = 2'd3
   } state_e;
endpackage

// File: rtl/hbm_wr_arbiter_if.sv
// AXI write-channel bundle (AW/W/B) between the arbiter (master) and the HBM port (slave).
interface hbm_wr_arbiter_if
   import hbm_arb_pkg::*;
#(
   parameter int AW = AXI_AW,
   parameter int DW = AXI_DW
);
   logic [AW-1:0]    AXI_AWADDR;
   logic [LEN_W-1:0] AXI_AWLEN;
   logic [2:0]       AXI_AWSIZE;
   logic [1:0]       AXI_AWBURST;
   logic [ID_W-1:0]  AXI_AWID;
   logic             AXI_AWVALID;
   logic             AXI_AWREADY;
   logic [DW-1:0]    AXI_WDATA;
   logic [DW/8-1:0]  AXI_WSTRB;
   logic             AXI_WLAST;
   logic             AXI_WVALID;
   logic             AXI_WREADY;
   logic [ID_W-1:0]  AXI_BID;
   logic [1:0]       AXI_BRESP;
   logic             AXI_BVALID;
   logic             AXI_BREADY;

   modport master (
      output AXI_AWADDR, AXI_AWLEN, AXI_AWSIZE, AXI_AWBURST, AXI_AWID, AXI_AWVALID,
      output AXI_WDATA, AXI_WSTRB, AXI_WLAST, AXI_WVALID, AXI_BREADY,
      input  AXI_AWREADY, AXI_WREADY, AXI_BID, AXI_BRESP, AXI_BVALID
   );

   modport slave (
      input  AXI_AWADDR, AXI_AWLEN, AXI_AWSIZE, AXI_AWBURST, AXI_AWID, AXI_AWVALID,
      input  AXI_WDATA, AXI_WSTRB, AXI_WLAST, AXI_WVALID, AXI_BREADY,
      output AXI_AWREADY, AXI_WREADY, AXI_BID, AXI_BRESP, AXI_BVALID
   );
endinterface

// File: rtl/hbm_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping at N.
module rr_pick
   import hbm_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]     req,
   input  logic [GID_W-1:0] ptr,
   output logic [N-1:0]     onehot,
   output logic [GID_W-1:0] idx,
   output logic             any
);
   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      for (int k = 0; k < N; k++) begin
         int cand;
         cand = int'(ptr) + k;
         if (cand >= N) cand = cand - N;
         for (int i = 0; i < N; i++) begin
            if (!any && (i == cand) && req[i]) begin
               any       = 1'b1;
               idx       = GID_W'(i);
               onehot[i] = 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/hbm_wr_arbiter.sv
// Burst-granular round-robin arbiter sharing one AXI write port among N_REQ clients,
// with a single burst outstanding: AW, then routed W beats, then B.
module hbm_wr_arbiter
   import hbm_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int AW    = AXI_AW,
   parameter int DW    = AXI_DW
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*AW-1:0]    req_addr,
   input  logic [N_REQ*LEN_W-1:0] req_len,
   input  logic [N_REQ*DW-1:0]    cli_wdata,
   input  logic [N_REQ-1:0]       cli_wvalid,
   output logic [N_REQ-1:0]       cli_wready,
   output logic [N_REQ-1:0]       done,
   output logic                   done_err,
   output logic [GID_W-1:0]       grant_id,
   hbm_wr_arbiter_if.master       axi
);
   state_e           state_q, state_d;
   logic [GID_W-1:0] gnt_q, gnt_d;
   logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [N_REQ-1:0] done_q, done_d;
   logic             err_q, err_d;

   logic [N_REQ-1:0] pick_oh;
   logic [GID_W-1:0] pick_idx;
   logic             pick_any;
   logic [N_REQ-1:0] gnt_oh;
   logic [AW-1:0]    sel_addr;
   logic [LEN_W-1:0] sel_len;
   logic [DW-1:0]    sel_wdata;
   logic             sel_wvalid;
   logic             aw_hs, w_hs, last_beat;
   logic             unused_bid;

   rr_pick #(.N(N_REQ)) u_pick (
      .req    (req_valid),
      .ptr    (rr_ptr_q),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   // Request-side mux follows the fresh pick; W-side mux follows the held grant.
   always_comb begin
      sel_addr   = '0;
      sel_len    = '0;
      sel_wdata  = '0;
      sel_wvalid = 1'b0;
      gnt_oh     = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_idx == GID_W'(i)) begin
            sel_addr = req_addr[i*AW +: AW];
            sel_len  = req_len[i*LEN_W +: LEN_W];
         end
         if (gnt_q == GID_W'(i)) begin
            sel_wdata  = cli_wdata[i*DW +: DW];
            sel_wvalid = cli_wvalid[i];
            gnt_oh[i]  = 1'b1;
         end
      end
   end

   assign aw_hs      = (state_q == AWR) && axi.AXI_AWREADY;
   assign w_hs       = (state_q == WR) && sel_wvalid && axi.AXI_WREADY;
   assign last_beat  = (cnt_q == len_q);
   assign unused_bid = ^axi.AXI_BID;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         rr_ptr_q <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         done_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         rr_ptr_q <= rr_ptr_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      rr_ptr_d = rr_ptr_q;
      addr_d   = addr_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      done_d   = '0;
      err_d    = 1'b0;
      unique case (state_q)
         IDLE: if (pick_any) begin
            gnt_d   = pick_idx;
            addr_d  = sel_addr;
            len_d   = sel_len;
            state_d = AWR;
         end
         AWR: if (aw_hs) begin
            cnt_d   = '0;
            state_d = WR;
         end
         WR: if (w_hs) begin
            cnt_d = cnt_q + LEN_W'(1);
            if (last_beat) state_d = BR;
         end
         BR: if (axi.AXI_BVALID) begin
            done_d   = gnt_oh;
            err_d    = (axi.AXI_BRESP != 2'b00);
            rr_ptr_d = (gnt_q == GID_W'(N_REQ-1)) ? '0 : gnt_q + GID_W'(1);
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready       = (state_q == IDLE && !rst) ? pick_oh : '0;
      cli_wready      = (state_q == WR && axi.AXI_WREADY) ? gnt_oh : '0;
      done            = done_q;
      done_err        = err_q;
      grant_id        = gnt_q;
      axi.AXI_AWVALID = (state_q == AWR);
      axi.AXI_AWADDR  = addr_q;
      axi.AXI_AWLEN   = len_q;
      axi.AXI_AWID    = ID_W'(gnt_q);
      axi.AXI_AWSIZE  = (state_q == AWR) ? AXI_SIZE_16B : 3'b000;
      axi.AXI_AWBURST = (state_q == AWR) ? AXI_BURST_INCR : 2'b00;
      axi.AXI_WVALID  = (state_q == WR) && sel_wvalid;
      axi.AXI_WDATA   = sel_wdata;
      axi.AXI_WSTRB   = '1;
      axi.AXI_WLAST   = (state_q == WR) && last_beat;
      axi.AXI_BREADY  = (state_q == BR);
   end
endmodule

// File: tb/tb_hbm_wr_arbiter.sv
// Bench for hbm_wr_arbiter: vector table of request scenarios driven through a cycle
// engine with an AW/W/done scoreboard, plus a hand-written mid-burst reset sequence.
module tb_hbm_wr_arbiter;
   import hbm_arb_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid, req_ready, cli_wvalid, cli_wready, done;
   logic [115:0] req_addr;
   logic [31:0]  req_len;
   logic [511:0] cli_wdata;
   logic         done_err;
   logic [2:0]   grant_id;

   hbm_wr_arbiter_if #(.AW(29), .DW(128)) axi ();

   hbm_wr_arbiter #(.N_REQ(4), .AW(29), .DW(128)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_len(req_len), .cli_wdata(cli_wdata),
      .cli_wvalid(cli_wvalid), .cli_wready(cli_wready), .done(done),
      .done_err(done_err), .grant_id(grant_id), .axi(axi)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      bit          rst_first;
      logic [3:0]  mask;
      logic [7:0]  len;
      logic [28:0] base;
      bit          stall;
      logic [1:0]  bresp1;
      int          n;
      logic [11:0] order;
   } vec_t;

   typedef struct { int cli; logic [28:0] addr; logic [7:0] len; } burst_t;
   typedef struct { int cli; logic err; } done_t;

   int          total, bad, vid;
   burst_t      exp_q[$];
   done_t       done_q[$];
   bit          done_due, w_phase, b_pend, aw_hold;
   int          cur_cli, wbeat;
   logic [7:0]  cur_len;
   int          cli_beat[4];
   logic [3:0]  acc;
   logic [43:0] aw_snap;
   vec_t        vecs[8];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (vec %0d)", nm, act, exp, vid);
      end
   endtask

   function automatic logic [127:0] pat(input int c, input int v, input int b);
      logic [31:0] w;
      w = {c[7:0], v[7:0], b[15:0]};
      return {4{w}};
   endfunction

   function automatic logic [11:0] ord4(input int a, input int b, input int c, input int d);
      return {d[2:0], c[2:0], b[2:0], a[2:0]};
   endfunction

   task automatic clear_model();
      exp_q.delete();
      done_q.delete();
      done_due = 0; w_phase = 0; b_pend = 0; aw_hold = 0; wbeat = 0; acc = '0;
   endtask

   task automatic quiet_inputs();
      req_valid = '0; cli_wvalid = '0;
      axi.AXI_AWREADY = 1'b0; axi.AXI_WREADY = 1'b0;
      axi.AXI_BVALID = 1'b0; axi.AXI_BRESP = 2'b00; axi.AXI_BID = 4'd0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      quiet_inputs();
      clear_model();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_awvalid", axi.AXI_AWVALID, 0);
      chk("rst_wvalid", axi.AXI_WVALID, 0);
      chk("rst_bready", axi.AXI_BREADY, 0);
      chk("rst_aw_fields", {axi.AXI_AWADDR, axi.AXI_AWLEN, axi.AXI_AWID}, 0);
      chk("rst_outs", {req_ready, done, done_err, grant_id}, 0);
   endtask

   task automatic run_vec(input vec_t v, input int abort_beat);
      int         cyc, ndone, nacc;
      logic [11:0] got;
      done_t      d;
      burst_t     e;
      cyc = 0; ndone = 0; nacc = 0; got = '0;
      if (v.rst_first) do_reset();
      vid++;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         cli_beat[i] = 0;
         req_addr[i*29 +: 29] = v.base + 29'(i * 32'h1000);
         req_len[i*8 +: 8]    = v.len;
      end
      req_valid = v.mask;
      while (ndone < v.n) begin
         if (cyc++ > 4000) begin
            chk("timeout", 1, 0);
            break;
         end
         axi.AXI_AWREADY = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
         axi.AXI_WREADY  = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
         for (int i = 0; i < 4; i++) begin
            cli_wvalid[i] = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            cli_wdata[i*128 +: 128] = pat(i, vid, cli_beat[i]);
         end
         axi.AXI_BVALID = b_pend && (v.stall ? 1'($urandom_range(0, 1)) : 1'b1);
         axi.AXI_BRESP  = (cur_cli == 1) ? v.bresp1 : 2'b00;
         axi.AXI_BID    = 4'(cur_cli);
         #1;
         // done must land exactly one cycle after the B handshake
         if (done_due && done_q.size() > 0) begin
            d = done_q.pop_front();
            chk("done", done, 4'b0001 << d.cli);
            chk("done_err", done_err, d.err);
            ndone++;
            done_due = 0;
         end else begin
            chk("done_idle", {done, done_err}, 0);
         end
         chk("wready_iso", cli_wready & ~(w_phase ? (4'b0001 << cur_cli) : 4'b0000), 0);
         chk("w_before_aw", axi.AXI_WVALID & ~w_phase, 0);
         chk("ready_wo_valid", req_ready & ~req_valid, 0);
         acc = req_ready & req_valid;
         for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
               exp_q.push_back('{i, req_addr[i*29 +: 29], req_len[i*8 +: 8]});
               if (nacc < 4) got[nacc*3 +: 3] = 3'(i);
               nacc++;
            end
         end
         if (axi.AXI_AWVALID) begin
            if (aw_hold)
               chk("aw_stable", {axi.AXI_AWADDR, axi.AXI_AWLEN, axi.AXI_AWID, axi.AXI_AWSIZE},
                   aw_snap);
            if (axi.AXI_AWREADY) begin
               if (exp_q.size() == 0) chk("aw_unexpected", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("awaddr", axi.AXI_AWADDR, e.addr);
                  chk("awlen", axi.AXI_AWLEN, e.len);
                  chk("awid", axi.AXI_AWID, e.cli);
                  chk("awsize_burst", {axi.AXI_AWSIZE, axi.AXI_AWBURST}, 5'b100_01);
                  w_phase = 1; cur_cli = e.cli; cur_len = e.len; wbeat = 0;
               end
               aw_hold = 0;
            end else begin
               aw_hold = 1;
               aw_snap = {axi.AXI_AWADDR, axi.AXI_AWLEN, axi.AXI_AWID, axi.AXI_AWSIZE};
            end
         end else aw_hold = 0;
         if (axi.AXI_WVALID && axi.AXI_WREADY && w_phase) begin
            chk("wdata", axi.AXI_WDATA, pat(cur_cli, vid, wbeat));
            chk("wlast", axi.AXI_WLAST, wbeat == int'(cur_len));
            chk("wstrb", axi.AXI_WSTRB, 16'hFFFF);
            if (wbeat == int'(cur_len)) begin
               w_phase = 0;
               b_pend  = 1;
            end
            wbeat++;
         end
         for (int i = 0; i < 4; i++)
            if (cli_wvalid[i] && cli_wready[i]) cli_beat[i]++;
         if (axi.AXI_BVALID && axi.AXI_BREADY) begin
            done_q.push_back('{cur_cli, (cur_cli == 1) && (v.bresp1 != 2'b00)});
            done_due = 1;
            b_pend   = 0;
         end
         @(negedge clk);
         req_valid = req_valid & ~acc;
         if (abort_beat > 0 && wbeat >= abort_beat) break;
      end
      for (int k = 0; k < v.n; k++) chk({v.name, "_order"}, got[k*3 +: 3], v.order[k*3 +: 3]);
      if (abort_beat == 0) chk({v.name, "_grant_id"}, grant_id, v.order[(v.n-1)*3 +: 3]);
   endtask

   initial begin
      vec_t av;
      total = 0; bad = 0; vid = 0; cur_cli = 0; cur_len = '0;
      rst = 1'b1; req_addr = '0; req_len = '0; cli_wdata = '0;
      quiet_inputs();
      do_reset();

      vecs[0] = '{"single0",   1'b0, 4'b0001, 8'h63, 29'h0010_0000, 1'b0, 2'b00, 1, ord4(0, 0, 0, 0)};
      vecs[1] = '{"all4",      1'b1, 4'b1111, 8'h03, 29'h0020_0000, 1'b0, 2'b00, 4, ord4(0, 1, 2, 3)};
      vecs[2] = '{"solo0",     1'b0, 4'b0001, 8'h01, 29'h0030_0000, 1'b0, 2'b00, 1, ord4(0, 0, 0, 0)};
      vecs[3] = '{"rr_2_0",    1'b0, 4'b0101, 8'h02, 29'h0040_0000, 1'b0, 2'b00, 2, ord4(2, 0, 0, 0)};
      vecs[4] = '{"stall",     1'b0, 4'b1111, 8'h07, 29'h0050_0000, 1'b1, 2'b00, 4, ord4(1, 2, 3, 0)};
      vecs[5] = '{"len0",      1'b0, 4'b0010, 8'h00, 29'h0060_0000, 1'b0, 2'b00, 1, ord4(1, 0, 0, 0)};
      vecs[6] = '{"bresp_err", 1'b0, 4'b0010, 8'h02, 29'h0070_0000, 1'b0, 2'b10, 1, ord4(1, 0, 0, 0)};
      vecs[7] = '{"after_err", 1'b0, 4'b0010, 8'h01, 29'h0080_0000, 1'b0, 2'b00, 1, ord4(1, 0, 0, 0)};
      for (int n = 0; n < 8; n++) run_vec(vecs[n], 0);

      // Abort client 2 at beat 40; reset must clear rr_ptr so 0 beats 3 afterwards.
      av = '{"abort2", 1'b0, 4'b0100, 8'h63, 29'h0090_0000, 1'b0, 2'b00, 1, ord4(2, 0, 0, 0)};
      run_vec(av, 40);
      rst = 1'b1;
      quiet_inputs();
      @(posedge clk);
      #1;
      chk("abort_valids", {axi.AXI_AWVALID, axi.AXI_WVALID, axi.AXI_WLAST, axi.AXI_BREADY}, 0);
      chk("abort_outs", {done, done_err, grant_id}, 0);
      @(negedge clk);
      rst = 1'b0;
      clear_model();
      av = '{"post_rst", 1'b0, 4'b1001, 8'h04, 29'h00A0_0000, 1'b0, 2'b00, 2, ord4(0, 3, 0, 0)};
      run_vec(av, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
